rr_arb_mux_4to1: RTL and testbench
==================================

// Module: rr_arb_mux_4to1
// PURPOSE
// - Round-robin arbiter and output register that shares one downstream channel among 4 requesters.
// - Each requester presents valid + data. The block picks one winner per accept, drives the
//   4:1 select internally and registers the winning word with its source id.
// - Sits in front of any single-consumer resource fed by four producers.
// PARAMETERS
// DATA_W   8   width of each requester data word and of out_data
// PORTS
// clk        in   1          single clock, rising edge
// rst_n      in   1          synchronous reset, active-low
// in_valid   in   4          in_valid[i]: requester i has a word
// in_data    in   4*DATA_W   requester i word at in_data[i*DATA_W +: DATA_W]
// in_ready   out  4          one-hot accept strobe; in_ready[i]=1 -> word i taken this cycle
// out_valid  out  1          out_data/out_sel hold a word
// out_data   out  DATA_W     registered winning word
// out_sel    out  2          registered source id of out_data
// out_ready  in   1          downstream accepts when out_valid & out_ready
// BEHAVIOUR
// - Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n), sampled on the
//   rising edge of clk.
// - Reset values: state=EMPTY, out_valid=0, out_data=0, out_sel=2'b00, last_sel=2'b11.
//   in_ready is combinational and is 0 while rst_n=0.
// - FSM has two states, EMPTY and FULL; out_valid = (state==FULL).
// - cap = |in_valid && (state==EMPTY || out_ready); cap is the capture enable.
// - Round-robin pick:
//   - Search order starts at last_sel+1 (mod 4) and runs last_sel+2, last_sel+3, last_sel.
//   - win = first index in that order with in_valid set.
//   - After reset the order is 0,1,2,3.
// - in_ready = cap ? (4'b0001 << win) : 4'b0000. It is combinational and never multi-hot.
// - On cap at the clock edge: out_data <= in_data[win], out_sel <= win, last_sel <= win, state <= FULL.
// - Transitions:
//   - EMPTY & !|in_valid -> EMPTY.
//   - EMPTY & |in_valid -> FULL (capture).
//   - FULL & !out_ready -> FULL. out_data and out_sel are held stable; in_ready=0.
//   - FULL & out_ready & |in_valid -> FULL. Back-to-back capture; the new word replaces the
//     old one in the same cycle.
//   - FULL & out_ready & !|in_valid -> EMPTY. out_data keeps its old value (don't-care).
// - Timing: latency is 1 cycle from in_valid to out_valid. Sustained throughput is 1 word/cycle
//   while out_ready=1.
// - Fairness: a requester holding in_valid is served within 4 accepts.
// - last_sel changes only on cap. A stall leaves priority unchanged.
// - Requester protocol: a requester keeps in_valid and in_data stable until it sees in_ready[i].
//   A requester dropping in_valid before in_ready is legal; it simply loses the slot.
// - Simultaneous events: all four valid -> the winner rotates each accept. A single requester
//   always wins. A new request arriving the same cycle as out_ready is captured with no bubble.
// - Reset mid-operation: a pending word is discarded, out_valid drops on the next edge, and
//   priority returns to order 0,1,2,3.
// STRUCTURE
// - Package arb_pkg:
//   - localparam N_REQ=4, SEL_W=2.
//   - State encoding: EMPTY=1'b0, FULL=1'b1.
//   - Function next_idx(idx) = idx+1 mod N_REQ.
// - Sub-module rr_pick4:
//   - Purely combinational. Inputs: req[3:0], last[1:0]. Outputs: any, win[1:0].
//   - Implemented as a rotate, fixed-priority, un-rotate chain.
// - Top-level contents: the FSM, last_sel, the output registers, and a case-based 4:1 word
//   select on win.
// TESTING
// - Reset: hold rst_n=0 for 3 cycles with in_valid=4'hF -> out_valid=0, in_ready=0,
//   out_sel=0 throughout.
// - Single requester: in_valid=4'b0100, word 8'hA5, out_ready=1 -> in_ready=4'b0100 the same
//   cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
// - Full rotation: in_valid=4'hF held, out_ready=1, words 8'h10..8'h13 -> out_sel sequence
//   0,1,2,3,0,... on consecutive cycles with no bubbles.
// - Backpressure: FULL with out_sel=1, out_ready=0 for 5 cycles, in_valid=4'hF -> out_data and
//   out_sel stable, in_ready=0; release -> next out_sel=2.
// - Skip idle requesters: last_sel=3, in_valid=4'b1010 -> win=1, then win=3, then win=1.
// - Mid-operation reset: reset asserted while FULL with out_sel=2 -> out_valid=0 next edge;
//   after release with in_valid=4'b1100, the first win is 2.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and index helper for the 4-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx + 2'd1;
  endfunction
endpackage

// File: rtl/rr_arb_mux_4to1_pick.sv
// Combinational round-robin pick: rotate requests so the search starts after last,
// take the lowest set bit, then rotate the index back.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);
  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] pos;

  assign start = next_idx(last);
  assign any   = |req;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + start];
    end
  end

  always_comb begin
    pos = '0;
    if (rot[0])      pos = 2'd0;
    else if (rot[1]) pos = 2'd1;
    else if (rot[2]) pos = 2'd2;
    else if (rot[3]) pos = 2'd3;
  end

  assign win = pos + start;
endmodule

// File: rtl/rr_arb_mux_4to1.sv
// Round-robin arbiter with a one-entry output register sharing one downstream channel
// among four requesters.
//
// state | meaning
// EMPTY | output register holds no word, out_valid=0
// FULL  | output register holds a word for the consumer, out_valid=1
module rr_arb_mux_4to1
  import arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);
  state_t           state;
  logic [SEL_W-1:0] last_sel;
  logic             any;
  logic [SEL_W-1:0] win;
  logic             cap;
  logic [DATA_W-1:0] win_data;

  rr_pick4 u_pick (
    .req  (in_valid),
    .last (last_sel),
    .any  (any),
    .win  (win)
  );

  // Gating with rst_n keeps in_ready low for the whole reset window.
  assign cap       = rst_n && any && (state == EMPTY || out_ready);
  assign in_ready  = cap ? (4'b0001 << win) : 4'b0000;
  assign out_valid = (state == FULL);

  always_comb begin
    win_data = '0;
    case (win)
      2'd0:    win_data = in_data[0*DATA_W +: DATA_W];
      2'd1:    win_data = in_data[1*DATA_W +: DATA_W];
      2'd2:    win_data = in_data[2*DATA_W +: DATA_W];
      2'd3:    win_data = in_data[3*DATA_W +: DATA_W];
      default: win_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      last_sel <= 2'b11;
    end else if (cap) begin
      state    <= FULL;
      out_data <= win_data;
      out_sel  <= win;
      last_sel <= win;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_rr_arb_mux_4to1.sv
// Self-checking bench for rr_arb_mux_4to1: directed scenarios plus a randomized run
// against a search-order reference model.
module tb_rr_arb_mux_4to1;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  int       m_last = 3;
  bit       m_full = 1'b0;
  logic [7:0] m_data = '0;
  logic [1:0] m_sel  = '0;

  rr_arb_mux_4to1 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int m_win();
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_cap();
    return (rst_n === 1'b1) && (in_valid != 4'b0) && (!m_full || out_ready);
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    r = 4'b0;
    if (m_cap()) r[m_win()] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    int w;
    if (rst_n !== 1'b1) begin
      m_full = 1'b0; m_last = 3; m_data = '0; m_sel = '0;
    end else if (m_cap()) begin
      w = m_win();
      m_data = in_data[w*8 +: 8];
      m_sel  = 2'(w);
      m_last = w;
      m_full = 1'b1;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; in_data = 32'h13121110; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_checks++;
      if (in_ready !== 4'b0) $display("FAIL reset_in_ready got %b want 0000", in_ready); else n_pass++;
      n_checks++;
      if (out_sel !== 2'd0) $display("FAIL reset_out_sel got %0d want 0", out_sel); else n_pass++;
      tick();
    end
  endtask

  task automatic test_single();
    rst_n = 1'b1; in_valid = 4'b0100; in_data = 32'h00A50000; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) $display("FAIL single_in_ready got %b want 0100", in_ready); else n_pass++;
    tick();
    in_valid = 4'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2)
      $display("FAIL single_out got v=%b d=%h s=%0d want v=1 d=a5 s=2", out_valid, out_data, out_sel);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_rotation();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; in_valid = 4'hF; in_data = 32'h13121110; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4))
        $display("FAIL rotation_%0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 i, out_valid, out_sel, out_data, i % 4, 8'h10 + i % 4);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; in_valid = 4'hF; in_data = 32'h13121110; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0 || out_sel !== 2'd1 || out_data !== 8'h11 || out_valid !== 1'b1)
        $display("FAIL stall_%0d got r=%b s=%0d d=%h v=%b want r=0000 s=1 d=11 v=1",
                 i, in_ready, out_sel, out_data, out_valid);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) $display("FAIL release_in_ready got %b want 0100", in_ready); else n_pass++;
    tick();
    n_checks++;
    if (out_sel !== 2'd2 || out_data !== 8'h12)
      $display("FAIL release_out got s=%0d d=%h want s=2 d=12", out_sel, out_data);
    else n_pass++;
  endtask

  task automatic test_skip();
    logic [3:0] exp_r [3];
    exp_r[0] = 4'b0010; exp_r[1] = 4'b1000; exp_r[2] = 4'b0010;
    rst_n = 1'b0; tick();
    rst_n = 1'b1; in_valid = 4'b1000; in_data = 32'hD3C2B1A0; out_ready = 1'b1;
    tick();
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== exp_r[i]) $display("FAIL skip_%0d got %b want %b", i, in_ready, exp_r[i]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; in_valid = 4'b0100; in_data = 32'h44332211; out_ready = 1'b0;
    tick();
    in_valid = 4'hF;
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2)
      $display("FAIL midrst_pre got v=%b s=%0d want v=1 s=2", out_valid, out_sel);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 4'b0) $display("FAIL midrst_in_ready got %b want 0000", in_ready); else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else n_pass++;
    rst_n = 1'b1; in_valid = 4'b1100; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) $display("FAIL midrst_first_win got %b want 0100", in_ready); else n_pass++;
    tick();
    n_checks++;
    if (out_sel !== 2'd2 || out_data !== 8'h33)
      $display("FAIL midrst_out got s=%0d d=%h want s=2 d=33", out_sel, out_data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      in_valid  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) in_valid = 4'b0;
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (in_ready !== m_ready())
        $display("FAIL rand_in_ready_%0d got %b want %b", i, in_ready, m_ready());
      else n_pass++;
      n_checks++;
      if (out_valid !== m_full ||
          (m_full && (out_sel !== m_sel || out_data !== m_data)))
        $display("FAIL rand_out_%0d got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                 i, out_valid, out_sel, out_data, m_full, m_sel, m_data);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_skip();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
